// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory and its burst port.
// Combinational fetch path; bursts take one beat per cycle.
// Burst beats use valid/ready handshakes; the core sees o_stall while a burst runs.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, two combinational read ports.
// Reads are zero-latency; a write becomes visible the cycle after its edge.
// No backpressure; the whole array clears in the reset cycle.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every word on reset, otherwise apply the single write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // Addresses beyond DEPTH-1 (non power-of-two depth) read as zero.
    always_comb begin
        rd0 = (32'(ra0) < DEPTH) ? mem[ra0] : '0;
        rd1 = (32'(ra1) < DEPTH) ? mem[ra1] : '0;
    end

endmodule

// File: rtl/imem_burst.sv
// Instruction memory with combinational core fetch and an external burst port.
// Write beats land one per accepted cycle; read data appears two cycles after start.
// Read beats hold in a one-entry register while rready is low; o_stall covers the burst.
module imem_burst
    import imem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_a,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_stall,
    input  logic              i_ex_start,
    input  logic              i_ex_mode,
    input  logic [ADDR_W-1:0] i_ex_a,
    input  logic [ADDR_W:0]   i_ex_len,
    input  logic              i_ex_wvalid,
    input  logic [DATA_W-1:0] i_ex_wd,
    output logic              o_ex_wready,
    output logic              o_ex_rvalid,
    output logic [DATA_W-1:0] o_ex_rd,
    input  logic              i_ex_rready,
    output logic              o_ex_busy,
    output logic              o_ex_done
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              wen;
    logic [DATA_W-1:0] burst_rd;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wen),
        .wa    (addr),
        .wd    (i_ex_wd),
        .ra0   (i_a),
        .rd0   (o_rd),
        .ra1   (addr),
        .rd1   (burst_rd)
    );

    // Address step with explicit wrap so non power-of-two depths stay in range.
    always_comb begin
        addr_nxt = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
        wen      = (state == ST_WRITE) && i_ex_wvalid;
        o_stall  = o_ex_busy;
    end

    // Burst FSM with registered handshake, busy and done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            cnt         <= '0;
            o_ex_wready <= 1'b0;
            o_ex_rvalid <= 1'b0;
            o_ex_rd     <= '0;
            o_ex_busy   <= 1'b0;
            o_ex_done   <= 1'b0;
        end else begin
            o_ex_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ex_start) begin
                        addr      <= i_ex_a;
                        cnt       <= i_ex_len;
                        o_ex_busy <= 1'b1;
                        if (i_ex_len == '0) begin
                            state     <= ST_DONE;
                            o_ex_done <= 1'b1;
                        end else if (i_ex_mode == MODE_WR) begin
                            state       <= ST_WRITE;
                            o_ex_wready <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_ex_wvalid) begin
                        addr <= addr_nxt;
                        cnt  <= cnt - 1'b1;
                        if (cnt == (ADDR_W+1)'(1)) begin
                            state       <= ST_DONE;
                            o_ex_wready <= 1'b0;
                            o_ex_done   <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // Refill the output register whenever it is empty or draining.
                    if (!o_ex_rvalid || i_ex_rready) begin
                        if (cnt != '0) begin
                            o_ex_rd     <= burst_rd;
                            o_ex_rvalid <= 1'b1;
                            addr        <= addr_nxt;
                            cnt         <= cnt - 1'b1;
                        end else begin
                            o_ex_rvalid <= 1'b0;
                            state       <= ST_DONE;
                            o_ex_done   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    o_ex_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
